// File: rtl/seq_det_pkg.sv
// Shared types and pure helpers for the 1011 sequence detector.
// The next-state and match functions are stateless, so one copy can serve every channel.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } det_state_t;

    function automatic det_state_t next_state(input det_state_t s, input logic b);
        case (s)
            IDLE:    return b ? S1    : IDLE;
            S1:      return b ? S1    : S10;
            S10:     return b ? S101  : IDLE;
            S101:    return b ? S1011 : S10;
            S1011:   return b ? S1    : S10;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic is_match(input det_state_t s, input logic b);
        return (s == S101) && b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = $clog2(N);
    localparam logic [PW:0] NL = (PW+1)'(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] nxt;
    logic [PW:0]   sum;
    logic          found;

    // Scan channels starting at ptr, wrapping modulo N; no grants while in reset.
    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        sum   = '0;
        if (rstn) begin
            for (int i = 0; i < N; i++) begin
                sum = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= NL) sum = sum - NL;
                if (!found && req[sum[PW-1:0]]) begin
                    found             = 1'b1;
                    gidx              = sum[PW-1:0];
                    gnt[sum[PW-1:0]]  = 1'b1;
                end
            end
        end
    end

    assign nxt = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= nxt;
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Multi-channel 1011 detector: one shared next-state function is time-shared
// across channels by a round-robin arbiter; each channel keeps its own state and counter.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH-1:0]           req_bit,
    output logic [NCH-1:0]           req_ready,
    input  logic                     clr_valid,
    input  logic [$clog2(NCH)-1:0]   clr_ch,
    output logic                     match_valid,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic [NCH*CNT_W-1:0]     match_cnt
);

    localparam int CW = $clog2(NCH);

    det_state_t       state [NCH];
    logic [CNT_W-1:0] cnt   [NCH];
    logic [NCH-1:0]   gnt;
    logic [CW-1:0]    gch;
    logic             hit;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .advance (|req_valid),
        .gnt     (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        gch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) gch = CW'(i);
        end
    end

    // A clear aimed at the granted channel swallows its bit, so no match can be reported.
    assign hit = (|gnt) && is_match(state[gch], req_bit[gch]) &&
                 !(clr_valid && (clr_ch == gch));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            match_valid <= 1'b0;
            match_ch    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr_valid && (clr_ch == CW'(i))) begin
                    state[i] <= IDLE;
                    cnt[i]   <= '0;
                end else if (gnt[i]) begin
                    state[i] <= next_state(state[i], req_bit[i]);
                    if (is_match(state[i], req_bit[i]) && (cnt[i] != '1)) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            match_valid <= hit;
            if (hit) match_ch <= gch;
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            match_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched (NCH=4, CNT_W=2 so saturation is reachable quickly).
module tb_seq_det_sched;

    localparam int NCH   = 4;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NCH-1:0]       req_valid;
    logic [NCH-1:0]       req_bit;
    logic [NCH-1:0]       req_ready;
    logic                 clr_valid;
    logic [1:0]           clr_ch;
    logic                 match_valid;
    logic [1:0]           match_ch;
    logic [NCH*CNT_W-1:0] match_cnt;

    int n_cmp = 0;
    int n_err = 0;

    seq_det_sched #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_bit     (req_bit),
        .req_ready   (req_ready),
        .clr_valid   (clr_valid),
        .clr_ch      (clr_ch),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return match_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // One transfer cycle: inputs applied on a falling edge, removed on the next one,
    // so registered outputs reflecting this cycle are visible on return.
    task automatic apply(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic cv, input logic [1:0] cc);
        @(negedge clk);
        req_valid = v;
        req_bit   = b;
        clr_valid = cv;
        clr_ch    = cc;
        @(negedge clk);
        req_valid = '0;
        req_bit   = '0;
        clr_valid = 1'b0;
        clr_ch    = '0;
    endtask

    task automatic send_bit(input int ch, input logic b);
        logic [NCH-1:0] v;
        logic [NCH-1:0] bb;
        v  = '0;
        bb = '0;
        v[ch]  = 1'b1;
        bb[ch] = b;
        apply(v, bb, 1'b0, 2'd0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = '1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_cmp++;
        if (match_valid !== 1'b0 || match_ch !== 2'd0 || match_cnt !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got mv=%b ch=%0d cnt=%h want 0/0/00",
                     match_valid, match_ch, match_cnt);
        end
        @(negedge clk);
        req_valid = '0;
        rstn      = 1'b1;
    endtask

    task automatic test_single();
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            send_bit(0, pat[k]);
            n_cmp++;
            if (match_valid !== (k == 3)) begin
                n_err++;
                $display("[TB] FAIL single_mv bit%0d: got %b want %b", k, match_valid, (k == 3));
            end
        end
        n_cmp++;
        if (match_ch !== 2'd0 || cnt_of(0) !== 2'd1) begin
            n_err++;
            $display("[TB] FAIL single_ch_cnt: got ch=%0d cnt=%0d want 0/1", match_ch, cnt_of(0));
        end
        @(negedge clk);
        n_cmp++;
        if (match_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_pulse_width: got %b want 0", match_valid);
        end
    endtask

    task automatic test_overlap();
        logic pat [7];
        logic exp [7];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            send_bit(2, pat[k]);
            n_cmp++;
            if (match_valid !== exp[k]) begin
                n_err++;
                $display("[TB] FAIL overlap_mv bit%0d: got %b want %b", k, match_valid, exp[k]);
            end
            if (k >= 3) begin
                n_cmp++;
                if (match_ch !== 2'd2) begin
                    n_err++;
                    $display("[TB] FAIL overlap_ch bit%0d: got %0d want 2", k, match_ch);
                end
            end
        end
        n_cmp++;
        if (cnt_of(2) !== 2'd2 || cnt_of(0) !== 2'd1) begin
            n_err++;
            $display("[TB] FAIL overlap_cnt: got c2=%0d c0=%0d want 2/1", cnt_of(2), cnt_of(0));
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp2 [4];
        exp2 = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = '1;
        req_bit   = '0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                n_err++;
                $display("[TB] FAIL rr_all cyc%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            end
            @(negedge clk);
        end
        req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== exp2[k]) begin
                n_err++;
                $display("[TB] FAIL rr_sparse cyc%0d: got %b want %b", k, req_ready, exp2[k]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || match_cnt !== 8'h00) begin
            n_err++;
            $display("[TB] FAIL rr_idle: got rdy=%b cnt=%h want 0000/00", req_ready, match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp [5];
        exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int r = 0; r < 5; r++) begin
            send_bit(1, 1'b1);
            send_bit(1, 1'b0);
            send_bit(1, 1'b1);
            send_bit(1, 1'b1);
            n_cmp++;
            if (match_valid !== 1'b1 || match_ch !== 2'd1 || cnt_of(1) !== exp[r]) begin
                n_err++;
                $display("[TB] FAIL sat rep%0d: got mv=%b ch=%0d cnt=%0d want 1/1/%0d",
                         r, match_valid, match_ch, cnt_of(1), exp[r]);
            end
        end
    endtask

    task automatic test_clear();
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        n_cmp++;
        if (cnt_of(0) !== 2'd1) begin
            n_err++;
            $display("[TB] FAIL clr_pre_cnt: got %0d want 1", cnt_of(0));
        end
        apply(4'b0001, 4'b0001, 1'b1, 2'd0);
        n_cmp++;
        if (match_valid !== 1'b0 || cnt_of(0) !== 2'd0) begin
            n_err++;
            $display("[TB] FAIL clr_same_ch: got mv=%b cnt=%0d want 0/0", match_valid, cnt_of(0));
        end
        send_bit(3, 1'b1);
        send_bit(3, 1'b0);
        send_bit(3, 1'b1);
        apply(4'b1000, 4'b1000, 1'b1, 2'd1);
        n_cmp++;
        if (match_valid !== 1'b1 || match_ch !== 2'd3 || cnt_of(3) !== 2'd1 || cnt_of(1) !== 2'd0) begin
            n_err++;
            $display("[TB] FAIL clr_other_ch: got mv=%b ch=%0d c3=%0d c1=%0d want 1/3/1/0",
                     match_valid, match_ch, cnt_of(3), cnt_of(1));
        end
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        n_cmp++;
        if (match_valid !== 1'b0 || match_ch !== 2'd3) begin
            n_err++;
            $display("[TB] FAIL clr_hold_ch: got mv=%b ch=%0d want 0/3", match_valid, match_ch);
        end
        send_bit(0, 1'b1);
        n_cmp++;
        if (match_valid !== 1'b1 || match_ch !== 2'd0 || cnt_of(0) !== 2'd1) begin
            n_err++;
            $display("[TB] FAIL clr_after: got mv=%b ch=%0d cnt=%0d want 1/0/1",
                     match_valid, match_ch, cnt_of(0));
        end
    endtask

    task automatic test_reset_mid();
        send_bit(3, 1'b1);
        send_bit(3, 1'b0);
        send_bit(3, 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        req_valid = '1;
        req_bit   = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("[TB] FAIL rst_ptr: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        send_bit(3, 1'b1);
        n_cmp++;
        if (match_valid !== 1'b0 || cnt_of(3) !== 2'd0) begin
            n_err++;
            $display("[TB] FAIL rst_discard: got mv=%b cnt=%0d want 0/0", match_valid, cnt_of(3));
        end
        send_bit(3, 1'b1);
        send_bit(3, 1'b0);
        send_bit(3, 1'b1);
        send_bit(3, 1'b1);
        n_cmp++;
        if (match_valid !== 1'b1 || match_ch !== 2'd3 || cnt_of(3) !== 2'd1) begin
            n_err++;
            $display("[TB] FAIL rst_rematch: got mv=%b ch=%0d cnt=%0d want 1/3/1",
                     match_valid, match_ch, cnt_of(3));
        end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        clr_valid = 1'b0;
        clr_ch    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_overlap();
        test_fairness();
        test_saturate();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
